simulate: RTL and testbench

SIMULATE -- requirements
Module: simulate

---
 rtl/simulate.sv | 95 +++++++++
 tb/tb_simulate.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simulate.sv
// rtl/simulate.sv - triangle-wave LED brightness ramp driving a PWM LED output
// simulate_ramp owns the prescaler and brightness level; simulate adds the PWM stage.

module simulate_ramp #(
    parameter int CNT_MAX = 1023,
    parameter int PWM_W   = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [10:0]      i_speed,
    output logic [PWM_W-1:0] o_level
);

    localparam logic [10:0] CNT_TOP = 11'(CNT_MAX);

    logic [10:0] r_presc;
    logic [10:0] r_count_cur;
    logic        r_dir;
    logic        tick;

    // >= rather than == so a lowered i_speed fires at once instead of waiting for a wrap
    assign tick = (r_presc >= i_speed);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= 11'd0;
        end else if (tick) begin
            r_presc <= 11'd0;
        end else begin
            r_presc <= r_presc + 11'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count_cur <= 11'd0;
            r_dir       <= 1'b0;
        end else if (tick) begin
            if (!r_dir) begin
                // Turn around on the peak itself so the top level lasts a single step
                if (r_count_cur >= CNT_TOP) begin
                    r_dir       <= 1'b1;
                    r_count_cur <= CNT_TOP - 11'd1;
                end else begin
                    r_count_cur <= r_count_cur + 11'd1;
                end
            end else begin
                if (r_count_cur == 11'd0) begin
                    r_dir       <= 1'b0;
                    r_count_cur <= 11'd1;
                end else begin
                    r_count_cur <= r_count_cur - 11'd1;
                end
            end
        end
    end

    assign o_level = r_count_cur[PWM_W-1:0];

endmodule

module simulate #(
    parameter int CNT_MAX = 1023,
    parameter int PWM_W   = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [10:0] i_speed,
    output logic        o_led
);

    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] r_pwm;

    simulate_ramp #(
        .CNT_MAX(CNT_MAX),
        .PWM_W  (PWM_W)
    ) simulate_cycle (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_speed(i_speed),
        .o_level(level)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm <= '0;
            o_led <= 1'b0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            o_led <= (r_pwm < level);
        end
    end

endmodule

// File: tb/tb_simulate.sv
// tb/tb_simulate.sv - directed self-checking bench for the simulate LED ramp

module tb_simulate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] speed = 11'd0;
    logic        led;

    int checks = 0;
    int errors = 0;

    simulate dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_speed(speed),
        .o_led  (led)
    );

    always #5 clk = ~clk;

    function automatic int tri_level(input int t);
        int p;
        p = t % 2046;
        return (p <= 1023) ? p : 2046 - p;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [10:0] spd);
        @(negedge clk);
        rst   = 1'b1;
        speed = spd;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", dut.simulate_cycle.r_count_cur);
        end
        checks++;
        if (dut.simulate_cycle.r_presc !== 11'd0) begin
            errors++; $display("FAIL reset_presc got %0d want 0", dut.simulate_cycle.r_presc);
        end
        checks++;
        if (dut.simulate_cycle.r_dir !== 1'b0) begin
            errors++; $display("FAIL reset_dir got %0b want 0", dut.simulate_cycle.r_dir);
        end
        checks++;
        if (dut.r_pwm !== 10'd0) begin
            errors++; $display("FAIL reset_pwm got %0d want 0", dut.r_pwm);
        end
        checks++;
        if (led !== 1'b0) begin
            errors++; $display("FAIL reset_led got %0b want 0", led);
        end
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_speed2;
        int bad = 0;
        int first_n = -1;
        int first_v = 0;
        int exp_v;
        do_reset(11'd2);
        for (int n = 1; n <= 6150; n++) begin
            step(1);
            exp_v = tri_level(n / 3);
            if (dut.simulate_cycle.r_count_cur > 11'd1023 ||
                int'(dut.simulate_cycle.r_count_cur) != exp_v) begin
                if (bad == 0) begin
                    first_n = n; first_v = int'(dut.simulate_cycle.r_count_cur);
                end
                bad++;
            end
            if (n == 3069) begin
                checks++;
                if (dut.simulate_cycle.r_count_cur !== 11'd1023) begin
                    errors++; $display("FAIL speed2_peak got %0d want 1023", dut.simulate_cycle.r_count_cur);
                end
            end
            if (n == 3072) begin
                checks++;
                if (dut.simulate_cycle.r_count_cur !== 11'd1022) begin
                    errors++; $display("FAIL speed2_after_peak got %0d want 1022", dut.simulate_cycle.r_count_cur);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL speed2_trace %0d bad cycles, first at clock %0d got %0d want %0d",
                     bad, first_n, first_v, tri_level(first_n / 3));
        end
    endtask

    task automatic test_speed0;
        int bad = 0;
        do_reset(11'd0);
        for (int n = 1; n <= 2047; n++) begin
            step(1);
            if (int'(dut.simulate_cycle.r_count_cur) != tri_level(n)) bad++;
            if (n == 1023) begin
                checks++;
                if (dut.simulate_cycle.r_count_cur !== 11'd1023) begin
                    errors++; $display("FAIL speed0_peak got %0d want 1023", dut.simulate_cycle.r_count_cur);
                end
            end
            if (n == 2046) begin
                checks++;
                if (dut.simulate_cycle.r_count_cur !== 11'd0) begin
                    errors++; $display("FAIL speed0_floor got %0d want 0", dut.simulate_cycle.r_count_cur);
                end
            end
            if (n == 2047) begin
                checks++;
                if (dut.simulate_cycle.r_count_cur !== 11'd1 || dut.simulate_cycle.r_dir !== 1'b0) begin
                    errors++; $display("FAIL speed0_rebound got level %0d dir %0b want level 1 dir 0",
                                       dut.simulate_cycle.r_count_cur, dut.simulate_cycle.r_dir);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL speed0_trace got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_led_zero;
        int highs = 0;
        do_reset(11'd2047);
        for (int n = 1; n <= 1000; n++) begin
            step(1);
            if (led !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL led_zero got %0d high clocks want 0", highs);
        end
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd0) begin
            errors++; $display("FAIL led_zero_level got %0d want 0", dut.simulate_cycle.r_count_cur);
        end
    endtask

    task automatic test_level512;
        int highs = 0;
        do_reset(11'd0);
        step(512);
        speed = 11'd2047;
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd512) begin
            errors++; $display("FAIL level512_setup got %0d want 512", dut.simulate_cycle.r_count_cur);
        end
        step(4);
        for (int n = 0; n < 1024; n++) begin
            step(1);
            if (led === 1'b1) highs++;
        end
        checks++;
        if (highs != 512) begin
            errors++; $display("FAIL level512_duty got %0d high clocks want 512", highs);
        end
    endtask

    task automatic test_speed_switch;
        do_reset(11'd100);
        step(50);
        checks++;
        if (dut.simulate_cycle.r_presc !== 11'd50) begin
            errors++; $display("FAIL switch_presc got %0d want 50", dut.simulate_cycle.r_presc);
        end
        speed = 11'd5;
        step(1);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd1 || dut.simulate_cycle.r_presc !== 11'd0) begin
            errors++; $display("FAIL switch_immediate got level %0d presc %0d want level 1 presc 0",
                               dut.simulate_cycle.r_count_cur, dut.simulate_cycle.r_presc);
        end
        step(5);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd1) begin
            errors++; $display("FAIL switch_hold got %0d want 1", dut.simulate_cycle.r_count_cur);
        end
        step(1);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd2) begin
            errors++; $display("FAIL switch_period1 got %0d want 2", dut.simulate_cycle.r_count_cur);
        end
        step(6);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd3) begin
            errors++; $display("FAIL switch_period2 got %0d want 3", dut.simulate_cycle.r_count_cur);
        end
    endtask

    task automatic test_async_reset;
        do_reset(11'd0);
        step(700);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd700) begin
            errors++; $display("FAIL async_setup got %0d want 700", dut.simulate_cycle.r_count_cur);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd0 || dut.simulate_cycle.r_presc !== 11'd0 ||
            dut.simulate_cycle.r_dir !== 1'b0 || dut.r_pwm !== 10'd0 || led !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got level %0d presc %0d dir %0b pwm %0d led %0b want all 0",
                     dut.simulate_cycle.r_count_cur, dut.simulate_cycle.r_presc,
                     dut.simulate_cycle.r_dir, dut.r_pwm, led);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd1) begin
            errors++; $display("FAIL async_restart1 got %0d want 1", dut.simulate_cycle.r_count_cur);
        end
        step(1);
        checks++;
        if (dut.simulate_cycle.r_count_cur !== 11'd2 || dut.simulate_cycle.r_dir !== 1'b0) begin
            errors++; $display("FAIL async_restart2 got level %0d dir %0b want level 2 dir 0",
                               dut.simulate_cycle.r_count_cur, dut.simulate_cycle.r_dir);
        end
    endtask

    initial begin
        test_reset();
        test_speed2();
        test_speed0();
        test_led_zero();
        test_level512();
        test_speed_switch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
